// File: rtl/spi_xfer_sequencer_if.sv
// spi_xfer_sequencer_if
// Bundles the command, TX/RX byte streams, status flags and the register bus
// of the SPI core that the sequencer drives.
//   master : the sequencer
//   slave  : the surrounding system (command source, stream endpoints, core)
interface spi_xfer_sequencer_if #(
   parameter int SS_WIDTH  = 16,
   parameter int LEN_WIDTH = 8
) ();

   // command
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [SS_WIDTH-1:0]  cmd_ss;
   logic [LEN_WIDTH-1:0] cmd_len;

   // TX byte stream into the sequencer
   logic                 tx_valid;
   logic                 tx_ready;
   logic [7:0]           tx_data;

   // RX byte stream out of the sequencer
   logic                 rx_valid;
   logic                 rx_ready;
   logic [7:0]           rx_data;

   // status
   logic                 busy;
   logic                 done;
   logic                 err;

   // SPI core register bus
   logic                 spi_select;
   logic [2:0]           spi_mem_addr;
   logic                 spi_read_n;
   logic                 spi_write_n;
   logic [15:0]          spi_wdata;
   logic [15:0]          spi_rdata;
   logic                 spi_readyfordata;
   logic                 spi_dataavailable;

   modport master (
      input  cmd_valid, cmd_ss, cmd_len,
      output cmd_ready,
      input  tx_valid, tx_data,
      output tx_ready,
      output rx_valid, rx_data,
      input  rx_ready,
      output busy, done, err,
      output spi_select, spi_mem_addr, spi_read_n, spi_write_n, spi_wdata,
      input  spi_rdata, spi_readyfordata, spi_dataavailable
   );

   modport slave (
      output cmd_valid, cmd_ss, cmd_len,
      input  cmd_ready,
      output tx_valid, tx_data,
      input  tx_ready,
      input  rx_valid, rx_data,
      output rx_ready,
      input  busy, done, err,
      input  spi_select, spi_mem_addr, spi_read_n, spi_write_n, spi_wdata,
      output spi_rdata, spi_readyfordata, spi_dataavailable
   );

endinterface

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
// Runs one multi-byte SPI transfer per accepted command through the register
// bus of an SPI core: program the slave-select mask, force SS on, then for each
// byte write TXDATA, wait for RXDATA, read it and hand it out on the RX stream,
// finally drop SS and pulse done. Every register access is exactly two cycles.
// A new TX byte is only written after the previous RX byte has been consumed,
// so the core can never overrun.
//
// Optional build macro: SPI_XFER_SEQ_ERRCHK_EN
//   When defined, the core status register is read after the last byte; if its
//   E bit (bit 8) is set, err is raised and the status register is cleared
//   before SS is dropped. When undefined, err is constant 0.
module spi_xfer_sequencer #(
   parameter int SS_WIDTH  = 16,
   parameter int LEN_WIDTH = 8
) (
   input logic                  clk,
   input logic                  reset_n,
   spi_xfer_sequencer_if.master bus
);

   // core register map
   localparam logic [2:0]  ADDR_RXDATA  = 3'd0;
   localparam logic [2:0]  ADDR_TXDATA  = 3'd1;
   localparam logic [2:0]  ADDR_STATUS  = 3'd2;
   localparam logic [2:0]  ADDR_CONTROL = 3'd3;
   localparam logic [2:0]  ADDR_SSMASK  = 3'd5;
   // control value with only SSO set; all interrupt enables stay 0
   localparam logic [15:0] CTRL_SSO     = 16'h0400;

   typedef enum logic [3:0] {
      IDLE,
      SS_WR,
      SSO_ON,
      TX_WAIT,
      TX_WR,
      RX_WAIT,
      RX_RD,
      RX_OUT,
`ifdef SPI_XFER_SEQ_ERRCHK_EN
      ST_RD,
      ST_CLR,
`endif
      SSO_OFF,
      DONE
   } state_t;

   state_t               state_reg,   state_next;
   logic                 phase_reg,   phase_next;    // 0: first, 1: second access cycle
   logic [LEN_WIDTH-1:0] cnt_reg,     cnt_next;      // bytes remaining minus one
   logic [SS_WIDTH-1:0]  ss_reg,      ss_next;
   logic [7:0]           tx_byte_reg, tx_byte_next;
   logic [7:0]           rx_data_reg, rx_data_next;
`ifdef SPI_XFER_SEQ_ERRCHK_EN
   logic                 err_reg,     err_next;
`endif

   // register-bus drive, decoded from the current state
   logic                 acc_sel;
   logic                 acc_rd_n;
   logic                 acc_wr_n;
   logic [2:0]           acc_addr;
   logic [15:0]          acc_wdata;

   // upper RX/status bits carry nothing this block needs
   logic                 unused_rdata;
   assign unused_rdata = ^bus.spi_rdata[15:8];

   // next-state, datapath and register-bus decode
   always_comb begin
      state_next   = state_reg;
      phase_next   = 1'b0;
      cnt_next     = cnt_reg;
      ss_next      = ss_reg;
      tx_byte_next = tx_byte_reg;
      rx_data_next = rx_data_reg;
`ifdef SPI_XFER_SEQ_ERRCHK_EN
      err_next     = err_reg;
`endif
      acc_sel      = 1'b0;
      acc_rd_n     = 1'b1;
      acc_wr_n     = 1'b1;
      acc_addr     = ADDR_RXDATA;
      acc_wdata    = 16'h0000;

      case (state_reg)
         IDLE: begin
            if (bus.cmd_valid) begin
               ss_next    = bus.cmd_ss;
               cnt_next   = bus.cmd_len;
`ifdef SPI_XFER_SEQ_ERRCHK_EN
               err_next   = 1'b0;
`endif
               state_next = SS_WR;
            end
         end
         SS_WR: begin
            acc_sel    = 1'b1;
            acc_wr_n   = 1'b0;
            acc_addr   = ADDR_SSMASK;
            acc_wdata  = 16'(ss_reg);
            phase_next = ~phase_reg;
            if (phase_reg) state_next = SSO_ON;
         end
         SSO_ON: begin
            acc_sel    = 1'b1;
            acc_wr_n   = 1'b0;
            acc_addr   = ADDR_CONTROL;
            acc_wdata  = CTRL_SSO;
            phase_next = ~phase_reg;
            if (phase_reg) state_next = TX_WAIT;
         end
         TX_WAIT: begin
            // SS stays forced on for as long as the TX source stalls
            if (bus.tx_valid && bus.spi_readyfordata) begin
               tx_byte_next = bus.tx_data;
               state_next   = TX_WR;
            end
         end
         TX_WR: begin
            acc_sel    = 1'b1;
            acc_wr_n   = 1'b0;
            acc_addr   = ADDR_TXDATA;
            acc_wdata  = {8'h00, tx_byte_reg};
            phase_next = ~phase_reg;
            if (phase_reg) state_next = RX_WAIT;
         end
         RX_WAIT: begin
            if (bus.spi_dataavailable) state_next = RX_RD;
         end
         RX_RD: begin
            acc_sel    = 1'b1;
            acc_rd_n   = 1'b0;
            acc_addr   = ADDR_RXDATA;
            phase_next = ~phase_reg;
            if (phase_reg) begin
               rx_data_next = bus.spi_rdata[7:0];
               state_next   = RX_OUT;
            end
         end
         RX_OUT: begin
            if (bus.rx_ready) begin
               cnt_next = cnt_reg - LEN_WIDTH'(1);
               if (cnt_reg == '0) begin
`ifdef SPI_XFER_SEQ_ERRCHK_EN
                  state_next = ST_RD;
`else
                  state_next = SSO_OFF;
`endif
               end else begin
                  state_next = TX_WAIT;
               end
            end
         end
`ifdef SPI_XFER_SEQ_ERRCHK_EN
         ST_RD: begin
            acc_sel    = 1'b1;
            acc_rd_n   = 1'b0;
            acc_addr   = ADDR_STATUS;
            phase_next = ~phase_reg;
            if (phase_reg) begin
               if (bus.spi_rdata[8]) begin
                  err_next   = 1'b1;
                  state_next = ST_CLR;
               end else begin
                  state_next = SSO_OFF;
               end
            end
         end
         ST_CLR: begin
            acc_sel    = 1'b1;
            acc_wr_n   = 1'b0;
            acc_addr   = ADDR_STATUS;
            acc_wdata  = 16'h0000;
            phase_next = ~phase_reg;
            if (phase_reg) state_next = SSO_OFF;
         end
`endif
         SSO_OFF: begin
            acc_sel    = 1'b1;
            acc_wr_n   = 1'b0;
            acc_addr   = ADDR_CONTROL;
            acc_wdata  = 16'h0000;
            phase_next = ~phase_reg;
            if (phase_reg) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset abandons any transfer in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         phase_reg   <= 1'b0;
         cnt_reg     <= '0;
         ss_reg      <= '0;
         tx_byte_reg <= '0;
         rx_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         cnt_reg     <= cnt_next;
         ss_reg      <= ss_next;
         tx_byte_reg <= tx_byte_next;
         rx_data_reg <= rx_data_next;
      end
   end

`ifdef SPI_XFER_SEQ_ERRCHK_EN
   // sticky error flag, cleared when the next command is accepted
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= err_next;
      end
   end

   assign bus.err = err_reg;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.cmd_ready    = (state_reg == IDLE);
   assign bus.busy         = (state_reg != IDLE);
   assign bus.done         = (state_reg == DONE);
   assign bus.tx_ready     = (state_reg == TX_WAIT) & bus.tx_valid & bus.spi_readyfordata;
   assign bus.rx_valid     = (state_reg == RX_OUT);
   assign bus.rx_data      = rx_data_reg;

   assign bus.spi_select   = acc_sel;
   assign bus.spi_read_n   = acc_rd_n;
   assign bus.spi_write_n  = acc_wr_n;
   assign bus.spi_mem_addr = acc_addr;
   assign bus.spi_wdata    = acc_wdata;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer
// Directed bench for spi_xfer_sequencer with a loopback SPI core model that
// logs every completed register access as {wr, addr, data}.
// Honours SPI_XFER_SEQ_ERRCHK_EN the same way the design does.
module tb_spi_xfer_sequencer;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   spi_xfer_sequencer_if #(.SS_WIDTH(16), .LEN_WIDTH(8)) bus ();

   spi_xfer_sequencer #(.SS_WIDTH(16), .LEN_WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

`ifdef SPI_XFER_SEQ_ERRCHK_EN
   localparam int EXP_LAT = 5;
`else
   localparam int EXP_LAT = 3;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- SPI core model ----------------
   logic [15:0] status_force;
   int          core_lat;
   int          shift_cnt;
   logic        dataavail;
   logic [7:0]  rxbuf;
   logic        sso;
   logic        sel_phase;
   logic        f_wr;
   logic [2:0]  f_addr;
   logic [15:0] f_wdata;
   int          proto_viol = 0;
   int          rxw_viol   = 0;
   int          busy_viol  = 0;
   int          cyc        = 0;
   logic [19:0] log_q[$];

   assign bus.spi_readyfordata  = (shift_cnt == 0);
   assign bus.spi_dataavailable = dataavail;
   assign bus.spi_rdata = (bus.spi_mem_addr == 3'd0) ? {8'h00, rxbuf} :
                          (bus.spi_mem_addr == 3'd2) ? status_force : 16'h0000;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset_n) begin
         shift_cnt <= 0;
         dataavail <= 1'b0;
         rxbuf     <= 8'h00;
         sso       <= 1'b0;
         sel_phase <= 1'b0;
      end else begin
         if (bus.busy && bus.cmd_ready) busy_viol <= busy_viol + 1;
         if (!bus.spi_write_n && bus.rx_valid) rxw_viol <= rxw_viol + 1;
         if (shift_cnt != 0) begin
            shift_cnt <= shift_cnt - 1;
            if (shift_cnt == 1) dataavail <= 1'b1;
         end
         if (bus.spi_select) begin
            if (bus.spi_read_n == bus.spi_write_n) proto_viol <= proto_viol + 1;
            if (!sel_phase) begin
               sel_phase <= 1'b1;
               f_wr      <= !bus.spi_write_n;
               f_addr    <= bus.spi_mem_addr;
               f_wdata   <= bus.spi_wdata;
            end else begin
               sel_phase <= 1'b0;
               if (f_wr != !bus.spi_write_n || f_addr != bus.spi_mem_addr || f_wdata != bus.spi_wdata)
                  proto_viol <= proto_viol + 1;
               if (!bus.spi_write_n) begin
                  log_q.push_back({1'b1, bus.spi_mem_addr, bus.spi_wdata});
                  if (bus.spi_mem_addr == 3'd1) begin
                     shift_cnt <= core_lat;
                     rxbuf     <= bus.spi_wdata[7:0];
                  end
                  if (bus.spi_mem_addr == 3'd3) sso <= bus.spi_wdata[10];
               end else begin
                  log_q.push_back({1'b0, bus.spi_mem_addr, bus.spi_rdata});
                  if (bus.spi_mem_addr == 3'd0) dataavail <= 1'b0;
               end
            end
         end else begin
            if (sel_phase || !bus.spi_read_n || !bus.spi_write_n) proto_viol <= proto_viol + 1;
            sel_phase <= 1'b0;
         end
      end
   end

   // ---------------- stream endpoints and monitors ----------------
   logic [7:0] tx_q[$];
   logic       tx_hs = 1'b0;
   logic [7:0] rx_q[$];
   int         rx_hold     = 0;
   int         rx_wcnt     = 0;
   int         rx_last_cyc = 0;
   logic       rx_pend     = 1'b0;
   logic [7:0] rx_prev     = 8'h00;
   int         stab_viol   = 0;
   int         done_cnt    = 0;
   int         done_cyc_q[$];
   int         acc_cyc_q[$];

   // TX source: presents queued bytes, pops one per handshake
   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (tx_hs) void'(tx_q.pop_front());
         tx_hs = 1'b0;
         if (tx_q.size() > 0) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = tx_q[0];
         end else begin
            bus.tx_valid = 1'b0;
         end
         #1;
         tx_hs = bus.tx_valid && bus.tx_ready;
      end
   end

   // RX sink: optionally stalls each byte for rx_hold cycles
   initial begin
      bus.rx_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rx_hold == 0) begin
            bus.rx_ready = 1'b1;
         end else if (bus.rx_valid) begin
            bus.rx_ready = (rx_wcnt >= rx_hold);
            rx_wcnt++;
         end else begin
            bus.rx_ready = 1'b0;
            rx_wcnt      = 0;
         end
         #1;
         if (rx_pend && bus.rx_valid && bus.rx_data != rx_prev) stab_viol++;
         rx_pend = bus.rx_valid && !bus.rx_ready;
         rx_prev = bus.rx_data;
         if (bus.rx_valid && bus.rx_ready) begin
            rx_q.push_back(bus.rx_data);
            rx_last_cyc = cyc;
         end
      end
   end

   // done pulses and command acceptances
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (bus.done) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
         end
         if (bus.cmd_valid && bus.cmd_ready) acc_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, tests_failed=%0d", tests_failed);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic int count_wr(input logic [2:0] addr);
      int n = 0;
      foreach (log_q[i]) if (log_q[i][19] && log_q[i][18:16] == addr) n++;
      return n;
   endfunction

   task automatic send_cmd(input logic [15:0] ss, input logic [7:0] len);
      int n = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_ss    = ss;
      bus.cmd_len   = len;
      #1;
      while (!bus.cmd_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("cmd_accept", 32'(n < 100), 32'd1);
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      check(tag, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic wait_log(input int target, input int budget, input string tag);
      int n = 0;
      while (log_q.size() < target && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      check(tag, 32'(log_q.size() >= target), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},      32'(bus.busy),         32'd0);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready),    32'd1);
      check({tag, "_select"},    32'(bus.spi_select),   32'd0);
      check({tag, "_read_n"},    32'(bus.spi_read_n),   32'd1);
      check({tag, "_write_n"},   32'(bus.spi_write_n),  32'd1);
      check({tag, "_addr"},      32'(bus.spi_mem_addr), 32'd0);
      check({tag, "_wdata"},     32'(bus.spi_wdata),    32'd0);
      check({tag, "_rx_valid"},  32'(bus.rx_valid),     32'd0);
      check({tag, "_rx_data"},   32'(bus.rx_data),      32'd0);
      check({tag, "_done"},      32'(bus.done),         32'd0);
      check({tag, "_err"},       32'(bus.err),          32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [19:0] exp_q[$];
      int d0;
      int a0;
      int dq0;
      int n0;
      int n;
      int bad;
      int sz;

      reset_n       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_ss    = 16'h0000;
      bus.cmd_len   = 8'h00;
      status_force  = 16'h0000;
      core_lat      = 4;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // single byte, loopback A5
      log_q.delete();
      rx_q.delete();
      d0 = done_cnt;
      tx_q.push_back(8'hA5);
      repeat (2) @(negedge clk);
      send_cmd(16'h0001, 8'd0);
      #1;
      check("t1_first_write_sel", 32'(bus.spi_select),   32'd1);
      check("t1_first_write_wn",  32'(bus.spi_write_n),  32'd0);
      check("t1_first_write_adr", 32'(bus.spi_mem_addr), 32'd5);
      check("t1_busy",            32'(bus.busy),         32'd1);
      wait_done(d0 + 1, 200, "t1_done");
      repeat (5) @(negedge clk);
      #2;
      check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("t1_rx_count",    32'(rx_q.size()),   32'd1);
      check("t1_rx_data",     32'(rx_q[0]),       32'hA5);
      check("t1_rx_to_done",  32'(done_cyc_q[$] - rx_last_cyc), 32'(EXP_LAT));
      exp_q = '{ {1'b1, 3'd5, 16'h0001}, {1'b1, 3'd3, 16'h0400},
                 {1'b1, 3'd1, 16'h00A5}, {1'b0, 3'd0, 16'h00A5} };
`ifdef SPI_XFER_SEQ_ERRCHK_EN
      exp_q.push_back({1'b0, 3'd2, 16'h0000});
`endif
      exp_q.push_back({1'b1, 3'd3, 16'h0000});
      check("t1_log_len", 32'(log_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) check($sformatf("t1_log%0d", i), 32'(log_q[i]), 32'(exp_q[i]));

      // four bytes, RX consumer stalls 50 cycles per byte
      log_q.delete();
      rx_q.delete();
      d0      = done_cnt;
      rx_hold = 50;
      for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
      send_cmd(16'h0003, 8'd3);
      wait_done(d0 + 1, 3000, "t2_done");
      check("t2_rx_count", 32'(rx_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("t2_rx%0d", i), 32'(rx_q[i]), 32'(i + 1));
      check("t2_txdata_writes", 32'(count_wr(3'd1)), 32'd4);
      rx_hold = 0;

      // TX source silent for 1000 cycles after SS goes on
      log_q.delete();
      rx_q.delete();
      d0 = done_cnt;
      send_cmd(16'h0001, 8'd0);
      wait_log(2, 20, "t3_sso_on");
      n0 = log_q.size();
      repeat (1000) @(negedge clk);
      #2;
      check("t3_no_access", 32'(log_q.size()), 32'(n0));
      check("t3_busy",      32'(bus.busy),     32'd1);
      check("t3_sso_held",  32'(sso),          32'd1);
      tx_q.push_back(8'h5C);
      wait_done(d0 + 1, 200, "t3_done");
      check("t3_rx_data", 32'(rx_q[0]), 32'h5C);

      // cmd_valid held high across a transfer
      rx_q.delete();
      d0  = done_cnt;
      a0  = acc_cyc_q.size();
      dq0 = done_cyc_q.size();
      tx_q.push_back(8'h11);
      tx_q.push_back(8'h22);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_ss    = 16'h0002;
      bus.cmd_len   = 8'd0;
      n = 0;
      while (acc_cyc_q.size() < a0 + 2 && n < 500) begin
         @(negedge clk);
         #2;
         n++;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("t4_accepts",      32'(acc_cyc_q.size() - a0), 32'd2);
      check("t4_accept_after", 32'(acc_cyc_q[a0 + 1]),    32'(done_cyc_q[dq0] + 1));
      wait_done(d0 + 2, 200, "t4_done");
      check("t4_rx0", 32'(rx_q[0]), 32'h11);
      check("t4_rx1", 32'(rx_q[1]), 32'h22);

      // reset while waiting for RX data
      core_lat = 30;
      log_q.delete();
      tx_q.push_back(8'h77);
      send_cmd(16'h0001, 8'd0);
      wait_log(3, 50, "t5_tx_written");
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check_idle_outputs("t5_reset");
      n0 = log_q.size();
      repeat (50) @(negedge clk);
      #2;
      check("t5_no_sso_off", 32'(log_q.size()), 32'(n0));
      check("t5_sso_cleared", 32'(sso), 32'd0);
      core_lat = 4;

      // core status reports an error
      log_q.delete();
      rx_q.delete();
      d0           = done_cnt;
      status_force = 16'h0100;
      tx_q.push_back(8'h3C);
      send_cmd(16'h0001, 8'd0);
      wait_done(d0 + 1, 200, "t6_done");
      check("t6_rx_data", 32'(rx_q[0]), 32'h3C);
      sz = log_q.size();
`ifdef SPI_XFER_SEQ_ERRCHK_EN
      check("t6_err", 32'(bus.err), 32'd1);
      check("t6_st_rd",  32'(log_q[sz - 3]), 32'({1'b0, 3'd2, 16'h0100}));
      check("t6_st_clr", 32'(log_q[sz - 2]), 32'({1'b1, 3'd2, 16'h0000}));
`else
      check("t6_err", 32'(bus.err), 32'd0);
      check("t6_rx_rd", 32'(log_q[sz - 2]), 32'({1'b0, 3'd0, 16'h003C}));
`endif
      check("t6_sso_off", 32'(log_q[sz - 1]), 32'({1'b1, 3'd3, 16'h0000}));
      status_force = 16'h0000;
      d0           = done_cnt;
      tx_q.push_back(8'h3D);
      send_cmd(16'h0001, 8'd0);
      #1;
      check("t6_err_cleared", 32'(bus.err), 32'd0);
      wait_done(d0 + 1, 200, "t6b_done");

      // maximum length: cmd_len all ones moves 256 bytes
      log_q.delete();
      rx_q.delete();
      d0 = done_cnt;
      for (int i = 0; i < 256; i++) tx_q.push_back(8'(i ^ 8'h5A));
      send_cmd(16'h8000, 8'hFF);
      wait_done(d0 + 1, 10000, "t7_done");
      check("t7_rx_count", 32'(rx_q.size()), 32'd256);
      bad = 0;
      foreach (rx_q[i]) if (rx_q[i] != 8'(i ^ 8'h5A)) bad++;
      check("t7_rx_bad_bytes",   32'(bad),            32'd0);
      check("t7_txdata_writes",  32'(count_wr(3'd1)), 32'd256);
      check("t7_ssmask",         32'(log_q[0]),       32'({1'b1, 3'd5, 16'h8000}));

      // bus-wide invariants collected over the whole run
      repeat (3) @(negedge clk);
      #2;
      check("bus_protocol",    32'(proto_viol), 32'd0);
      check("write_during_rx", 32'(rxw_viol),   32'd0);
      check("ready_while_busy", 32'(busy_viol), 32'd0);
      check("rx_data_stable",  32'(stab_viol),  32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameter SS_WIDTH, default 16, width of the slave-select mask written to SPI register 5.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of cmd_len; bytes per transfer = cmd_len+1.
REQ-003 SHALL have ports: clk in 1 system clock; reset_n in 1 reset, synchronous, active-low.
REQ-004 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_ss in SS_WIDTH slave mask; cmd_len in LEN_WIDTH byte count minus one.
REQ-005 SHALL have TX stream ports: tx_valid in 1; tx_ready out 1; tx_data in 8.
REQ-006 SHALL have RX stream ports: rx_valid out 1; rx_ready in 1; rx_data out 8.
REQ-007 SHALL have status ports: busy out 1; done out 1 single-cycle pulse; err out 1 sticky until next cmd accept.
REQ-008 SHALL have SPI-core ports: spi_select out 1; spi_mem_addr out 3; spi_read_n out 1; spi_write_n out 1; spi_wdata out 16; spi_rdata in 16; spi_readyfordata in 1; spi_dataavailable in 1.

Function
REQ-009 SHALL perform every SPI-core register access as exactly 2 cycles: spi_select=1, addr and data stable, with read_n or write_n low; in all other cycles select=0 and read_n=write_n=1.
REQ-010 SHALL sample spi_rdata at the end of the 2nd cycle of a read access.
REQ-011 SHALL use states IDLE, SS_WR, SSO_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, RX_OUT, [ST_RD, ST_CLR], SSO_OFF, DONE.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, latch cmd_ss and cmd_len, clear err, go to SS_WR.
REQ-013 SS_WR: write addr 5 with cmd_ss zero-extended to 16 bits; then SSO_ON.
REQ-014 SSO_ON: write addr 3 with 16'h0400 (SSO=1, all IRQ enables 0); then TX_WAIT.
REQ-015 TX_WAIT: tx_ready=tx_valid&spi_readyfordata is combinational; on the handshake, latch tx_data and go to TX_WR; with tx_valid low, wait indefinitely while SS stays asserted.
REQ-016 TX_WR: write addr 1 with {8'h00,byte}; then RX_WAIT.
REQ-017 RX_WAIT: wait for spi_dataavailable=1; then RX_RD (read addr 0), latching spi_rdata[7:0]; then RX_OUT.
REQ-018 RX_OUT: hold rx_valid=1 and rx_data stable until rx_ready; on the handshake, decrement the byte counter and go to TX_WAIT if bytes remain, otherwise to ST_RD (macro defined) or SSO_OFF.
REQ-019 The next TX write SHALL NOT start before the previous RX byte is consumed, so core overrun cannot arise from this block.
REQ-020 SSO_OFF: write addr 3 with 16'h0000; DONE asserts done for 1 cycle, then IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE; cmd_ready SHALL be 0 whenever busy.
REQ-022 The byte counter SHALL be LEN_WIDTH bits; cmd_len = all-ones SHALL transfer 2^LEN_WIDTH bytes with no wrap error.
REQ-023 Minimum latency for a 1-byte transfer with tx_valid, rx_ready and core flags already high: cmd accept -> first SPI write in next cycle; RX_OUT -> done = 3 cycles (no macro).

Reset
REQ-024 While reset_n=0 at a clk edge: state=IDLE, spi_select=0, spi_read_n=spi_write_n=1, spi_mem_addr=0, spi_wdata=0, rx_valid=0, rx_data=0, done=0, err=0, busy=0, counter=0.
REQ-025 Reset mid-transfer SHALL abandon the transfer with no SSO_OFF write; the SPI core SHALL share reset_n so that SSO clears.

Configuration
REQ-026 Macro SPI_XFER_SEQ_ERRCHK_EN defined:
- after the last RX handshake, ST_RD reads addr 2.
- If bit 8 (E) is set, set err, then ST_CLR writes addr 2 with 0 before SSO_OFF.
- If E is clear, skip ST_CLR.
REQ-027 Macro undefined: ST_RD and ST_CLR absent; err tied 0.

Verification
REQ-028 cmd_ss=16'h0001, cmd_len=0, tx 8'hA5, MISO loopback -> writes addr5=0001, addr3=0400, addr1=00A5, read addr0; rx_data=8'hA5; addr3=0000; one done pulse.
REQ-029 cmd_len=3, tx 01,02,03,04 with rx_ready held low 50 cycles per byte -> exactly 4 addr1 writes, never a write while rx_valid=1, rx order 01..04.
REQ-030 tx_valid low 1000 cycles after SSO_ON -> no SPI accesses, busy=1, SS stays asserted; then resumes correctly.
REQ-031 cmd_valid held high during busy -> cmd_ready=0, second command accepted only in the cycle after done.
REQ-032 reset_n pulled low mid RX_WAIT for 1 cycle -> all REQ-024 values on the next edge, IDLE, cmd_ready=1.
REQ-033 ERRCHK_EN with core status forced to 16'h0100 -> err=1, addr2 write 0000 precedes the addr3=0000 write; without the macro err=0.
